spu_sm_sum_reci: RTL and testbench
==================================

SPU_SM_SUM_RECI -- requirements
Module: spu_sm_sum_reci

Interface
REQ-001 SHALL have port core_clk  input  1  clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port sm_state  input  3  softmax phase: IDLE=000, EU_STAGE_A=001, RECI=011, EU_STAGE_B=100, MAX=101.
REQ-004 SHALL have port exp_valid  input  1  lanes exp_q_0..3 carry a valid beat this cycle.
REQ-005 SHALL have ports exp_q_0, exp_q_1, exp_q_2, exp_q_3  input  8 each  unsigned exp outputs from the upstream EXPU lanes.
REQ-006 SHALL have port busy  output  1  high while the divider iterates.
REQ-007 SHALL have port reci_valid  output  1  one-cycle pulse when reci_q is updated.
REQ-008 SHALL have port reci_q  output  16  unsigned reciprocal floor(2^24 / sum), saturated.
REQ-009 SHALL have port sum_ovf  output  1  sticky overflow flag for the accumulated sum.

Function
REQ-010 SHALL implement FSM states S_IDLE, S_ACC, S_DIV and S_DONE.
REQ-011 SHALL go S_IDLE->S_ACC on the first edge sampling sm_state==EU_STAGE_A, clearing sum and sum_ovf on that edge.
REQ-012 SHALL, in S_ACC, add exp_q_0+exp_q_1+exp_q_2+exp_q_3 to a 20-bit unsigned sum on every edge with exp_valid=1; exp_valid in any other state is ignored.
REQ-013 SHALL, on the first edge sampling sm_state==RECI, latch sum as the divisor, assert busy and enter S_DIV; this is edge 1.
REQ-014 SHALL use a serial restoring divider of dividend 2^24, producing one quotient bit per edge over exactly 25 iteration edges (edges 2..26).
REQ-015 SHALL, on edge 26, load reci_q, pulse reci_valid high for one cycle, deassert busy and enter S_DONE.
REQ-016 SHALL saturate reci_q to 0xFFFF when the quotient exceeds 16 bits (sum <= 256) or when sum==0, while still keeping the 26-edge latency.
REQ-017 SHALL hold reci_q between updates; S_DONE SHALL return to S_IDLE when sm_state!=RECI.
REQ-018 SHALL, if sm_state leaves RECI during S_DIV, abort to S_IDLE without pulsing reci_valid, leaving reci_q unchanged.
REQ-019 SHALL, if sm_state goes directly from EU_STAGE_A to any state other than RECI, keep the sum and return to S_IDLE.

Reset
REQ-020 SHALL, on rst_n low and at any time including mid-division, asynchronously set the FSM to S_IDLE and clear sum, the divider registers, busy, reci_valid, reci_q (0x0000) and sum_ovf.

Configuration
REQ-021 SHALL, when macro SPU_SM_SUM_SAT_EN is defined, saturate sum at 0xFFFFF and set sum_ovf sticky on any carry out.
REQ-022 SHALL, when SPU_SM_SUM_SAT_EN is undefined, let sum wrap modulo 2^20 and tie sum_ovf to 0.

Structure
REQ-023 SHALL take the sm_state encodings, SUM_W=20, RECI_W=16, NUM_SHIFT=24 and DIV_ITER=25 from the shared package spu_sm_pkg.
REQ-024 SHALL place the divider in one sub-module spu_sm_reci_div, with ports start, divisor[19:0], busy, done and quot[15:0] (saturated).

Verification
REQ-025 SHALL cover this scenario: 4 beats of all lanes =64 (sum 1024), then RECI -> reci_q=0x4000, reci_valid on edge 26.
REQ-026 SHALL cover this scenario: single beat of lanes 255,1,1,0 (sum 257), then RECI -> reci_q=65280 (0xFF00).
REQ-027 SHALL cover this scenario: no valid beats (sum 0), then RECI -> reci_q=0xFFFF after 26 edges; sum 256 -> also 0xFFFF.
REQ-028 SHALL cover this scenario: sm_state RECI->IDLE at edge 10 of the divide -> no reci_valid, reci_q keeps its prior value, busy low next cycle.
REQ-029 SHALL cover this scenario: 1100 beats of all 255 (sum 1,122,000) -> with the macro, sum=0xFFFFF and sum_ovf=1; without it, sum wraps to 73,424 and reci_q=228.
REQ-030 SHALL cover this scenario: rst_n pulsed low asynchronously mid-S_DIV -> all outputs 0 immediately, FSM in S_IDLE.

Source files
------------

// File: rtl/spu_sm_pkg.sv
// Shared softmax definitions: phase encodings, datapath widths and the
// reciprocal saturation helper used by the sum/reciprocal block.
package spu_sm_pkg;

  localparam int SUM_W     = 20;
  localparam int RECI_W    = 16;
  localparam int NUM_SHIFT = 24;
  localparam int DIV_ITER  = 25;
  localparam int EXP_W     = 8;
  localparam int BEAT_W    = EXP_W + 2;
  localparam int CNT_W     = $clog2(DIV_ITER);

  typedef enum logic [2:0] {
    SM_IDLE = 3'b000,
    SM_EU_A = 3'b001,
    SM_RECI = 3'b011,
    SM_EU_B = 3'b100,
    SM_MAX  = 3'b101
  } sm_state_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } fsm_e;

  // Quotients wider than RECI_W (divisor <= 256) and divide-by-zero clamp to all ones.
  function automatic logic [RECI_W-1:0] sat_quot(input logic [DIV_ITER-1:0] q,
                                                 input logic                div_zero);
    if (div_zero || (|q[DIV_ITER-1:RECI_W])) return '1;
    return q[RECI_W-1:0];
  endfunction

endpackage

// File: rtl/spu_sm_reci_div.sv
// Serial restoring divider computing 2^NUM_SHIFT / divisor, one quotient bit
// per clock; done is asserted combinationally on the final iteration edge.
module spu_sm_reci_div
  import spu_sm_pkg::*;
(
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SUM_W-1:0]  divisor,
  output logic              busy,
  output logic              done,
  output logic [RECI_W-1:0] quot
);

  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W:0]      rem_q, rem_d;
  logic [DIV_ITER-1:0] quo_q, quo_d;
  logic [SUM_W-1:0]    div_q, div_d;

  logic [SUM_W:0]      rem_sh;
  logic [SUM_W:0]      rem_nx;
  logic [DIV_ITER-1:0] quo_nx;
  logic                ge;
  logic                last;

  // The dividend is a single set bit at NUM_SHIFT, fed in on the first iteration.
  always_comb begin
    rem_sh = {rem_q[SUM_W-1:0], (cnt_q == '0)};
    ge     = (rem_sh >= {1'b0, div_q});
    rem_nx = ge ? (rem_sh - {1'b0, div_q}) : rem_sh;
    quo_nx = {quo_q[DIV_ITER-2:0], ge};
    last   = busy_q && (cnt_q == CNT_W'(DIV_ITER - 1));
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = '0;
      div_d  = divisor;
    end else if (abort) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      rem_d = rem_nx;
      quo_d = quo_nx;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
    end
  end

  assign busy = busy_q;
  assign done = last && !abort;
  assign quot = sat_quot(quo_nx, (div_q == '0));

endmodule

// File: rtl/spu_sm_sum_reci.sv
// Softmax exp-sum accumulator and reciprocal unit. Define SPU_SM_SUM_SAT_EN to
// saturate the sum with a sticky overflow flag; otherwise the sum wraps.
module spu_sm_sum_reci
  import spu_sm_pkg::*;
(
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic [2:0]        sm_state,
  input  logic              exp_valid,
  input  logic [EXP_W-1:0]  exp_q_0,
  input  logic [EXP_W-1:0]  exp_q_1,
  input  logic [EXP_W-1:0]  exp_q_2,
  input  logic [EXP_W-1:0]  exp_q_3,
  output logic              busy,
  output logic              reci_valid,
  output logic [RECI_W-1:0] reci_q,
  output logic              sum_ovf
);

  fsm_e              state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              ovf_q, ovf_d;
  logic [RECI_W-1:0] reci_d;
  logic              reci_valid_q, reci_valid_d;

  logic [BEAT_W-1:0] beat;
  logic [SUM_W:0]    sum_add;
  logic [SUM_W-1:0]  sum_nx;
  logic              ovf_nx;

  logic              div_start;
  logic              div_abort;
  logic              div_busy;
  logic              div_done;
  logic [RECI_W-1:0] div_quot;

  always_comb begin
    beat    = BEAT_W'(exp_q_0) + BEAT_W'(exp_q_1) + BEAT_W'(exp_q_2) + BEAT_W'(exp_q_3);
    sum_add = {1'b0, sum_q} + (SUM_W+1)'(beat);
`ifdef SPU_SM_SUM_SAT_EN
    if (sum_add[SUM_W]) begin
      sum_nx = '1;
      ovf_nx = 1'b1;
    end else begin
      sum_nx = sum_add[SUM_W-1:0];
      ovf_nx = ovf_q;
    end
`else
    sum_nx = sum_add[SUM_W-1:0];
    ovf_nx = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    ovf_d        = ovf_q;
    reci_d       = reci_q;
    reci_valid_d = 1'b0;
    div_start    = 1'b0;
    div_abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sm_state == SM_EU_A) begin
          state_d = S_ACC;
          sum_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ACC: begin
        if (exp_valid) begin
          sum_d = sum_nx;
          ovf_d = ovf_nx;
        end
        if (sm_state == SM_RECI) begin
          div_start = 1'b1;
          state_d   = S_DIV;
        end else if (sm_state != SM_EU_A) begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        // Leaving RECI mid-divide drops the result; reci_q keeps its old value.
        if (sm_state != SM_RECI) begin
          div_abort = 1'b1;
          state_d   = S_IDLE;
        end else if (div_done) begin
          reci_d       = div_quot;
          reci_valid_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        if (sm_state != SM_RECI) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sum_q        <= '0;
      ovf_q        <= 1'b0;
      reci_q       <= '0;
      reci_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      ovf_q        <= ovf_d;
      reci_q       <= reci_d;
      reci_valid_q <= reci_valid_d;
    end
  end

  spu_sm_reci_div u_div (
    .core_clk (core_clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (div_abort),
    .divisor  (sum_q),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (div_quot)
  );

  assign busy       = div_busy;
  assign reci_valid = reci_valid_q;
  assign sum_ovf    = ovf_q;

endmodule

// File: tb/tb_spu_sm_sum_reci.sv
// Directed bench for spu_sm_sum_reci: accumulate, divide latency, saturation,
// abort, overflow/wrap and asynchronous reset mid-divide.
module tb_spu_sm_sum_reci;
  import spu_sm_pkg::*;

  logic        core_clk;
  logic        rst_n;
  logic [2:0]  sm_state;
  logic        exp_valid;
  logic [7:0]  exp_q_0, exp_q_1, exp_q_2, exp_q_3;
  logic        busy;
  logic        reci_valid;
  logic [15:0] reci_q;
  logic        sum_ovf;

  int n_vec;
  int n_err;

  spu_sm_sum_reci dut (
    .core_clk   (core_clk),
    .rst_n      (rst_n),
    .sm_state   (sm_state),
    .exp_valid  (exp_valid),
    .exp_q_0    (exp_q_0),
    .exp_q_1    (exp_q_1),
    .exp_q_2    (exp_q_2),
    .exp_q_3    (exp_q_3),
    .busy       (busy),
    .reci_valid (reci_valid),
    .reci_q     (reci_q),
    .sum_ovf    (sum_ovf)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic acc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                     input logic [7:0] d, input int n);
    sm_state  = SM_EU_A;
    exp_valid = 1'b0;
    step();
    exp_q_0 = a; exp_q_1 = b; exp_q_2 = c; exp_q_3 = d;
    if (n > 0) begin
      exp_valid = 1'b1;
      repeat (n) step();
    end
    exp_valid = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic [15:0] exp);
    sm_state = SM_RECI;
    repeat (25) step();
    chk({tag, "_busy_e25"}, busy, 1);
    chk({tag, "_vld_e25"}, reci_valid, 0);
    step();
    chk({tag, "_vld_e26"}, reci_valid, 1);
    chk({tag, "_reci"}, reci_q, exp);
    chk({tag, "_busy_e26"}, busy, 0);
    step();
    chk({tag, "_vld_e27"}, reci_valid, 0);
    sm_state = SM_IDLE;
    step();
  endtask

  initial begin
    logic saw;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    sm_state = SM_IDLE;
    exp_valid = 1'b0;
    exp_q_0 = '0; exp_q_1 = '0; exp_q_2 = '0; exp_q_3 = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_vld", reci_valid, 0);
    chk("rst_reci", reci_q, 0);
    chk("rst_ovf", sum_ovf, 0);
    #10 rst_n = 1'b1;
    step();

    acc(8'd64, 8'd64, 8'd64, 8'd64, 4);
    chk("sum1024", dut.sum_q, 1024);
    run_div("s1024", 16'h4000);

    acc(8'd64, 8'd64, 8'd64, 8'd64, 1);
    run_div("s256", 16'hFFFF);

    acc(8'd255, 8'd1, 8'd1, 8'd0, 1);
    run_div("s257", 16'hFF00);

    acc(8'd0, 8'd0, 8'd0, 8'd0, 0);
    run_div("s0", 16'hFFFF);

    // EU_STAGE_A straight to MAX: sum kept, FSM back to idle
    acc(8'd1, 8'd1, 8'd1, 8'd1, 1);
    sm_state = SM_MAX;
    step();
    chk("leave_state", dut.state_q, S_IDLE);
    chk("leave_sum", dut.sum_q, 4);
    sm_state = SM_IDLE;
    step();

    // Abort on divide edge 10
    acc(8'd64, 8'd64, 8'd64, 8'd64, 4);
    sm_state = SM_RECI;
    repeat (9) step();
    chk("abort_busy_pre", busy, 1);
    sm_state = SM_IDLE;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_reci", reci_q, 16'hFFFF);
    saw = reci_valid;
    repeat (20) begin
      step();
      saw = saw | reci_valid;
    end
    chk("abort_novld", saw, 0);
    chk("abort_reci_hold", reci_q, 16'hFFFF);

    // 1100 beats of 255 in every lane: sum 1,122,000
    acc(8'd255, 8'd255, 8'd255, 8'd255, 1100);
`ifdef SPU_SM_SUM_SAT_EN
    chk("ovf_sum", dut.sum_q, 32'h000F_FFFF);
    chk("ovf_flag", sum_ovf, 1);
    run_div("ovf", 16'd16);
`else
    chk("wrap_sum", dut.sum_q, 73424);
    chk("wrap_flag", sum_ovf, 0);
    run_div("wrap", 16'd228);
`endif

    // Asynchronous reset in the middle of a divide
    acc(8'd64, 8'd0, 8'd0, 8'd0, 1);
    sm_state = SM_RECI;
    repeat (5) step();
    chk("ar_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_vld", reci_valid, 0);
    chk("ar_reci", reci_q, 0);
    chk("ar_ovf", sum_ovf, 0);
    chk("ar_state", dut.state_q, S_IDLE);
    chk("ar_sum", dut.sum_q, 0);
    sm_state = SM_IDLE;
    #3 rst_n = 1'b1;
    step();
    step();
    chk("ar_idle_after", dut.state_q, S_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
